// File: rtl/async_fifo_pkg.sv
// Shared constants and types for the async_fifo FIFO exerciser.
// Every async_fifo file takes its widths from this package.
package async_fifo_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int RD_DIV = 10;
  localparam int DIV_W  = $clog2(RD_DIV);

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W:0]   ptr_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DIV_W-1:0]  div_t;

  // Word address inside the storage array; the wrap bit is dropped.
  function automatic addr_t ptr_addr(input ptr_t p);
    return p[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/async_fifo_if.sv
// Observation bundle of the FIFO exerciser: popped data and occupancy flags.
// The block drives it through master; consumers read it through slave.
interface async_fifo_if;
  import async_fifo_pkg::*;

  data_t dout;
  logic  r_empty;
  logic  w_full;

  modport master (output dout, output r_empty, output w_full);
  modport slave  (input  dout, input  r_empty, input  w_full);

endinterface

// File: rtl/async_fifo_fifo_ram.sv
// DEPTH x DATA_W storage with a synchronous write port and a registered read port.
// The read register holds its value between reads and clears on reset.
module async_fifo_fifo_ram
  import async_fifo_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  wr_en,
  input  addr_t wr_addr,
  input  data_t wr_data,
  input  logic  rd_en,
  input  addr_t rd_addr,
  output data_t rd_data
);

  data_t mem [DEPTH];

  // NOTE: the array has no reset branch so it can map onto plain RAM;
  // nothing reads an entry before a write has filled it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/async_fifo.sv
// Single-clock FIFO exerciser: a counter writes whenever there is room,
// and a paced reader pops one word every RD_DIV cycles.
module async_fifo
  import async_fifo_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  async_fifo_if.master bus
);

  ptr_t  wptr;
  ptr_t  rptr;
  data_t gen;
  div_t  div;

  logic  empty;
  logic  full;
  logic  rd_tick;
  logic  wr_en;
  logic  rd_en;
  data_t rd_data;

  // Both flags come straight from the registered pointers, so they settle
  // one edge after the operation that changed the occupancy.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                   (ptr_addr(wptr) == ptr_addr(rptr));
  assign rd_tick = (div == div_t'(RD_DIV - 1));
  assign wr_en   = !full;
  assign rd_en   = rd_tick && !empty;

  // NOTE: all state updates use non-blocking assignments, so every branch
  // sees the pre-edge pointers and flags even when both pointers move.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      gen  <= '0;
      div  <= '0;
    end else begin
      if (wr_en) begin
        wptr <= wptr + 1'b1;
        gen  <= gen + 1'b1;
      end
      if (rd_en) begin
        rptr <= rptr + 1'b1;
      end
      div <= rd_tick ? '0 : div + 1'b1;
    end
  end

  async_fifo_fifo_ram u_ram (
    .clk     (clk),
    .rst_n   (reset),
    .wr_en   (wr_en),
    .wr_addr (ptr_addr(wptr)),
    .wr_data (gen),
    .rd_en   (rd_en),
    .rd_addr (ptr_addr(rptr)),
    .rd_data (rd_data)
  );

  assign bus.dout    = rd_data;
  assign bus.r_empty = empty;
  assign bus.w_full  = full;

endmodule

// File: tb/tb_async_fifo.sv
// Directed bench for async_fifo: reset, first read, fill, full-with-read,
// long run across the 8-bit data wrap, and asynchronous reset mid-run.
module tb_async_fifo;
  import async_fifo_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   edge_n;

  async_fifo_if bus ();

  async_fifo dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, exp, edge_n);
      $error("check %s", tag);
    end
  endtask

  // Advance one rising edge and sample well clear of it.
  task automatic step();
    @(posedge clk);
    #2;
    edge_n++;
  endtask

  function automatic logic [31:0] occupancy();
    ptr_t d;
    d = dut.wptr - dut.rptr;
    return 32'(d);
  endfunction

  // Checks shared by the initial start-up and the restart after a mid-run reset.
  task automatic startup_sequence(input string pfx);
    edge_n = 0;
    step();
    check({pfx, "_e1_empty"}, 32'(bus.r_empty), 32'd0);
    check({pfx, "_e1_occ"},   occupancy(),       32'd1);
    while (edge_n < 10) step();
    check({pfx, "_e10_dout"}, 32'(bus.dout),     32'd0);
    check({pfx, "_e10_occ"},  occupancy(),       32'd9);
    while (edge_n < 17) step();
    check({pfx, "_e17_full"}, 32'(bus.w_full),   32'd1);
    check({pfx, "_e17_occ"},  occupancy(),       32'd16);
    while (edge_n < 19) step();
    check({pfx, "_e19_gen"},  32'(dut.gen),      32'd17);
    check({pfx, "_e19_dout"}, 32'(bus.dout),     32'd0);
    step();
    check({pfx, "_e20_dout"}, 32'(bus.dout),     32'd1);
    check({pfx, "_e20_full"}, 32'(bus.w_full),   32'd0);
    step();
    check({pfx, "_e21_full"}, 32'(bus.w_full),   32'd1);
    check({pfx, "_e21_gen"},  32'(dut.gen),      32'd18);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    edge_n = 0;
    reset  = 1'b0;

    // Reset held across a clock edge.
    @(posedge clk);
    #2;
    check("rst_dout",  32'(bus.dout),    32'd0);
    check("rst_empty", 32'(bus.r_empty), 32'd1);
    check("rst_full",  32'(bus.w_full),  32'd0);
    reset = 1'b1;

    startup_sequence("init");

    // Steady state: k-th read lands on edge 10k with value (k-1) mod 256;
    // the writer refills on the edge after each read.
    while (edge_n < 2600) begin
      step();
      check("run_dout",  32'(bus.dout),   32'(data_t'(edge_n / 10 - 1)));
      check("run_full",  32'(bus.w_full), (edge_n % 10 == 0) ? 32'd0 : 32'd1);
      check("run_empty", 32'(bus.r_empty), 32'd0);
      if (edge_n == 2560) check("read256_dout", 32'(bus.dout), 32'd255);
      if (edge_n == 2570) check("read257_dout", 32'(bus.dout), 32'd0);
    end

    // Asynchronous reset while full, between edges.
    step();
    check("pre_rst_full", 32'(bus.w_full), 32'd1);
    reset = 1'b0;
    #1;
    check("async_rst_full",  32'(bus.w_full),  32'd0);
    check("async_rst_empty", 32'(bus.r_empty), 32'd1);
    check("async_rst_dout",  32'(bus.dout),    32'd0);
    check("async_rst_gen",   32'(dut.gen),     32'd0);
    @(posedge clk);
    #2;
    check("rst_hold_occ", occupancy(), 32'd0);
    reset = 1'b1;

    startup_sequence("restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
